// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// datapath mux codes and the internal control-word layout.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_ONE    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Raw per-state control word; pcwrite/pcwritecond are folded into pcen by the top.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic [3:0] irwrite;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       pcwritecond;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decoder: maps the controller state to its datapath control word.
module mc_output_decode
  import mips_mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: default the whole word first so every state path assigns every bit (no latches).
    ctrl = '0;
    case (state)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_ONE;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.pcwrite  = 1'b1;
        ctrl.irwrite  = 4'b0001 << state[1:0];
      end
      DECODE:  ctrl.alusrcb = SRCB_BRANCH;
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      LBRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      LBWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      SBWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      RTYPEWR: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
      JEX: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      ADDIWR:  ctrl.regwrite = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle control FSM for the 8-bit MIPS datapath: state register,
// opcode dispatch, branch-qualified PC enable and reset gating of all outputs.
module mips_mc_controller
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic [3:0] irwrite,
  output logic [1:0] pcsource,
  output logic       pcen
);

  state_t state, next_state;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!reset_n) state <= FETCH1;
    else          state <= next_state;
  end

  always_comb begin
    next_state = FETCH1;
    case (state)
      FETCH1:  next_state = FETCH2;
      FETCH2:  next_state = FETCH3;
      FETCH3:  next_state = FETCH4;
      FETCH4:  next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_J:         next_state = JEX;
          OP_ADDI:      next_state = ADDIEX;
          default:      next_state = FETCH1;
        endcase
      end
      MEMADR:  next_state = (op == OP_SB) ? SBWR : LBRD;
      LBRD:    next_state = LBWR;
      RTYPEEX: next_state = RTYPEWR;
      ADDIEX:  next_state = ADDIWR;
      default: next_state = FETCH1;
    endcase
  end

  mc_output_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  // Reset level gates outputs directly so writes drop the moment reset_n falls.
  assign memread  = reset_n & ctrl.memread;
  assign memwrite = reset_n & ctrl.memwrite;
  assign alusrca  = reset_n & ctrl.alusrca;
  assign alusrcb  = {2{reset_n}} & ctrl.alusrcb;
  assign aluop    = {2{reset_n}} & ctrl.aluop;
  assign iord     = reset_n & ctrl.iord;
  assign memtoreg = reset_n & ctrl.memtoreg;
  assign regdst   = reset_n & ctrl.regdst;
  assign regwrite = reset_n & ctrl.regwrite;
  assign irwrite  = {4{reset_n}} & ctrl.irwrite;
  assign pcsource = {2{reset_n}} & ctrl.pcsource;
  assign pcen     = reset_n & (ctrl.pcwrite | (ctrl.pcwritecond & zero));

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: stimulus queues expected control
// words per cycle, a negedge monitor pops and compares them.
module tb_mips_mc_controller;
  import mips_mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] irwrite;

  mips_mc_controller dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (op),
    .zero     (zero),
    .memread  (memread),
    .memwrite (memwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .aluop    (aluop),
    .iord     (iord),
    .memtoreg (memtoreg),
    .regdst   (regdst),
    .regwrite (regwrite),
    .irwrite  (irwrite),
    .pcsource (pcsource),
    .pcen     (pcen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] w;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [17:0] act;

  assign act = {memread, memwrite, alusrca, alusrcb, aluop, iord, memtoreg,
                regdst, regwrite, irwrite, pcsource, pcen};

  // Field order: memread memwrite alusrca alusrcb aluop iord memtoreg regdst regwrite irwrite pcsource pcen
  function automatic logic [17:0] mk(input logic mr, input logic mw, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic io, input logic m2r, input logic rd,
                                     input logic rw, input logic [3:0] irw,
                                     input logic [1:0] pcs, input logic pe);
    return {mr, mw, asa, asb, aop, io, m2r, rd, rw, irw, pcs, pe};
  endfunction

  localparam logic [17:0] W_ZERO    = 18'h0;
  localparam logic [17:0] W_DECODE  = {5'b00011, 13'h0};
  localparam logic [17:0] W_MEMADR  = {5'b00110, 13'h0};
  localparam logic [17:0] W_ADDIEX  = {5'b00110, 13'h0};

  task automatic check(input string nm, input logic [17:0] a, input logic [17:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Monitor: every cycle the controller presents a control word.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.nm, act, e.w);
    end
  end

  task automatic step(input logic [17:0] w, input string nm);
    exp_t e;
    e.w  = w;
    e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input string tag);
    for (int n = 0; n < 4; n++)
      step(mk(1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 4'b0001 << n, 2'b00, 1),
           $sformatf("%s_fetch%0d", tag, n + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    op      = 6'h3f;
    zero    = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(W_ZERO, $sformatf("reset_cycle%0d", i));
    reset_n = 1'b1;

    // lb: 8 cycles, writeback from MDR in cycle 8
    op = OP_LB;
    do_fetch("lb");
    step(W_DECODE, "lb_decode");
    step(W_MEMADR, "lb_memadr");
    step(mk(1, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 4'b0000, 2'b00, 0), "lb_rd");
    step(mk(0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 1, 4'b0000, 2'b00, 0), "lb_wr");

    // beq taken
    op = OP_BEQ; zero = 1'b1;
    do_fetch("beq1");
    step(W_DECODE, "beq1_decode");
    step(mk(0, 0, 1, 2'b00, 2'b01, 0, 0, 0, 0, 4'b0000, 2'b01, 1), "beq1_ex");

    // beq not taken
    op = OP_BEQ; zero = 1'b0;
    do_fetch("beq0");
    step(W_DECODE, "beq0_decode");
    step(mk(0, 0, 1, 2'b00, 2'b01, 0, 0, 0, 0, 4'b0000, 2'b01, 0), "beq0_ex");

    // jump
    op = OP_J;
    do_fetch("j");
    step(W_DECODE, "j_decode");
    step(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 4'b0000, 2'b10, 1), "j_ex");

    // R-type with zero high: zero must not affect pcen outside BEQEX
    op = OP_RTYPE; zero = 1'b1;
    do_fetch("rt");
    step(W_DECODE, "rt_decode");
    step(mk(0, 0, 1, 2'b00, 2'b10, 0, 0, 0, 0, 4'b0000, 2'b00, 0), "rt_ex");
    step(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 4'b0000, 2'b00, 0), "rt_wr");
    zero = 1'b0;

    // addi
    op = OP_ADDI;
    do_fetch("addi");
    step(W_DECODE, "addi_decode");
    step(W_ADDIEX, "addi_ex");
    step(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 4'b0000, 2'b00, 0), "addi_wr");

    // unknown opcode behaves as NOP
    op = 6'b111111;
    do_fetch("nop");
    step(W_DECODE, "nop_decode");

    // sb, full
    op = OP_SB;
    do_fetch("sb");
    step(W_DECODE, "sb_decode");
    step(W_MEMADR, "sb_memadr");
    step(mk(0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0, 4'b0000, 2'b00, 0), "sb_wr");

    // sb aborted by reset in SBWR
    op = OP_SB;
    do_fetch("sba");
    step(W_DECODE, "sba_decode");
    step(W_MEMADR, "sba_memadr");
    check("sba_wr_before_reset", act,
          mk(0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0, 4'b0000, 2'b00, 0));
    reset_n = 1'b0;
    #1;
    check("sba_wr_drop", act, W_ZERO);
    step(W_ZERO, "sba_abort_cycle");
    step(W_ZERO, "sba_reset_hold");
    reset_n = 1'b1;
    op = 6'b111111;
    do_fetch("post_rst");
    step(W_DECODE, "post_rst_decode");
    step(mk(1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 4'b0001, 2'b00, 1), "post_rst_refetch");

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
